hex_display_scanner: RTL

- Time-multiplexed scanner for a DIGITS-wide common-anode 7-segment display.
- Sits directly upstream of the one-digit hex-to-segment decoder: each slot drives the decoder's nibble and dp inputs and selects one active-low anode.
- A load handshake double-buffers the displayed value. New values are applied only at frame boundaries, so the display never shows a partly updated value.
- A dead time at the start of each slot blanks all anodes to prevent ghosting. Optional leading-zero blanking is supported.

---
 rtl/hex_display_scanner_pkg.sv | 16 +
 rtl/hex_display_scanner_scan_timer.sv | 55 +++++
 rtl/hex_display_scanner.sv | 125 ++++++++++++
 3 files changed

// File: rtl/hex_display_scanner_pkg.sv
// Shared constants and helpers for the hex display scanner.
// Anode and dp polarities are both active-low at the pins.
package hex_display_scanner_pkg;

    localparam int DIGITS_MAX = 8;

    localparam logic [DIGITS_MAX-1:0] ANODE_OFF = '1;

    // dp_out is active-low: this value leaves the decimal point dark
    localparam logic DP_OFF = 1'b1;

    function automatic int slot_w(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/hex_display_scanner_scan_timer.sv
// Digit-slot timing: prescaler pre counts 0..DIV-1, slot advances on each wrap.
// Latency: outputs reflect the registered counters; pre_ge_dead looks at next pre.
// Backpressure: none, free-running.
module hex_display_scanner_scan_timer
    import hex_display_scanner_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int DEAD   = 16,
    localparam int SW    = slot_w(DIGITS)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [SW-1:0] slot,
    output logic          pre_ge_dead,
    output logic          slot_end,
    output logic          frame_end
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] pre;
    logic [PW-1:0] pre_nxt;
    logic [SW-1:0] slot_nxt;

    assign slot_end  = (pre == PW'(DIV - 1));
    assign frame_end = slot_end && (slot == SW'(DIGITS - 1));

    always_comb begin
        pre_nxt  = slot_end ? '0 : pre + PW'(1);
        slot_nxt = slot;
        if (frame_end)
            slot_nxt = '0;
        else if (slot_end)
            slot_nxt = slot + SW'(1);
    end

    // Anode registers sample this, so it must describe the pre value being loaded
    if (DEAD == 0) begin : g_no_dead
        assign pre_ge_dead = 1'b1;
    end else begin : g_dead
        assign pre_ge_dead = (pre_nxt >= PW'(DEAD));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre  <= '0;
            slot <= '0;
        end else begin
            pre  <= pre_nxt;
            slot <= slot_nxt;
        end
    end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed scanner for a common-anode 7-segment display with frame-aligned load.
// Latency: all outputs registered; a load shows up at the next frame boundary.
// Backpressure: none; a second load before the boundary overwrites the pending value.
module hex_display_scanner
    import hex_display_scanner_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int DEAD   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  lz_blank,
    output logic                  load_ack,
    output logic [3:0]            HEX_out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     anode_n,
    output logic                  frame_tick
);

    localparam int SW = slot_w(DIGITS);

    logic [SW-1:0]       slot;
    logic [SW-1:0]       slot_nxt;
    logic                pre_ge_dead;
    logic                slot_end;
    logic                frame_end;

    logic [4*DIGITS-1:0] disp_val;
    logic [4*DIGITS-1:0] disp_val_nxt;
    logic [4*DIGITS-1:0] pend_val;
    logic [DIGITS-1:0]   disp_dp;
    logic [DIGITS-1:0]   disp_dp_nxt;
    logic [DIGITS-1:0]   pend_dp;
    logic                pend_flag;
    logic                apply;

    logic [DIGITS-1:0]   blank;
    logic                zero_run;
    logic [DIGITS-1:0]   anode_nxt;

    hex_display_scanner_scan_timer #(
        .DIGITS (DIGITS),
        .DIV    (DIV),
        .DEAD   (DEAD)
    ) u_scan_timer (
        .clk         (clk),
        .reset       (reset),
        .slot        (slot),
        .pre_ge_dead (pre_ge_dead),
        .slot_end    (slot_end),
        .frame_end   (frame_end)
    );

    always_comb begin
        slot_nxt = slot;
        if (frame_end)
            slot_nxt = '0;
        else if (slot_end)
            slot_nxt = slot + SW'(1);
    end

    // A load on the boundary cycle itself is newer than anything pending
    assign apply = frame_end && (pend_flag || load);

    always_comb begin
        disp_val_nxt = disp_val;
        disp_dp_nxt  = disp_dp;
        if (apply) begin
            disp_val_nxt = load ? value_in : pend_val;
            disp_dp_nxt  = load ? dp_in    : pend_dp;
        end
    end

    // Walk down from the top digit while everything above is zero
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (disp_val_nxt[4*k +: 4] == 4'h0);
            blank[k] = lz_blank && zero_run && !disp_dp_nxt[k];
        end
    end

    always_comb begin
        anode_nxt = ANODE_OFF[DIGITS-1:0];
        if (pre_ge_dead && !blank[slot_nxt])
            anode_nxt[slot_nxt] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_val   <= '0;
            disp_dp    <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_flag  <= 1'b0;
            anode_n    <= ANODE_OFF[DIGITS-1:0];
            HEX_out    <= 4'h0;
            dp_out     <= DP_OFF;
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            disp_val <= disp_val_nxt;
            disp_dp  <= disp_dp_nxt;
            if (load) begin
                pend_val <= value_in;
                pend_dp  <= dp_in;
            end
            if (apply)
                pend_flag <= 1'b0;
            else if (load)
                pend_flag <= 1'b1;
            anode_n    <= anode_nxt;
            HEX_out    <= disp_val_nxt[{slot_nxt, 2'b00} +: 4];
            dp_out     <= DP_OFF ^ disp_dp_nxt[slot_nxt];
            load_ack   <= apply;
            frame_tick <= frame_end;
        end
    end

endmodule
